// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Shared types and constants for the multi-cycle ARM-style
//               shifter: shift operation encoding, controller states and
//               bit positions inside the {N,Z,C,V} flag vector.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

  // Shift operation encoding as presented on the op port.
  // Codes 5..7 are not named and behave as a zero-length LSL.
  typedef enum logic [2:0] {
    LSL = 3'd0,
    LSR = 3'd1,
    ASR = 3'd2,
    ROR = 3'd3,
    RRX = 3'd4
  } shift_op_t;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit positions inside the 4-bit {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational single-step shifter.
//               Moves value by k bit positions (0 <= k <= STEP) using the
//               selected operation and reports the last bit shifted out.
//   value   in  WIDTH            operand for this step
//   op      in  shift_op_t       LSL / LSR / ASR / ROR (others pass through)
//   k       in  clog2(STEP+1)    number of positions for this step
//   shifted out WIDTH            stepped value
//   carry   out 1                last bit shifted out (0 when k == 0)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0]           value,
  input  shift_op_t                  op,
  input  logic [$clog2(STEP+1)-1:0]  k,
  output logic [WIDTH-1:0]           shifted,
  output logic                       carry
);

  logic carry_lo;  // value[k-1]: last bit out of a right shift / rotate
  logic carry_hi;  // value[WIDTH-k]: last bit out of a left shift

  // Variable bit selection done as a compare-and-pick loop so the index
  // never leaves the vector when k is 0.
  always_comb begin
    carry_lo = 1'b0;
    carry_hi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == int'(k) - 1)     carry_lo = value[i];
      if (i == WIDTH - int'(k)) carry_hi = value[i];
    end
  end

  always_comb begin
    shifted = value;
    carry   = 1'b0;
    case (op)
      LSL: begin
        shifted = value << k;
        carry   = carry_hi;
      end
      LSR: begin
        shifted = value >> k;
        carry   = carry_lo;
      end
      ASR: begin
        shifted = $signed(value) >>> k;
        carry   = carry_lo;
      end
      ROR: begin
        // k == 0 makes the left term shift by WIDTH, which yields zero.
        shifted = (value >> k) | (value << (WIDTH - int'(k)));
        carry   = carry_lo;
      end
      default: begin
        shifted = value;
        carry   = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter
// Description : Multi-cycle ARM-style register-specified shifter.
//               Accepts one request over a valid/ready handshake, shifts
//               STEP bits per cycle and returns result plus {N,Z,C,V}.
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_ready  request handshake (op, rm, amt, cin)
//   out_valid/out_ready result handshake (rd, flags)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AMT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  rm,
  input  logic [AMT_W-1:0]  amt,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  rd,
  output logic [3:0]        flags
);

  // rem must hold WIDTH+1 (over-range LSL/LSR needs one extra step so the
  // carry ends up as the zero shifted in from the far side).
  localparam int          REM_W  = $clog2(WIDTH + 2);
  localparam int          KW     = $clog2(STEP + 1);
  localparam logic [63:0] LIM_LS = 64'(WIDTH + 1);
  localparam logic [63:0] LIM_AS = 64'(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   value_q, value_d;
  shift_op_t          op_q, op_d;
  logic               carry_q, carry_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   rd_q, rd_d;
  logic [3:0]         flags_q, flags_d;

  logic [63:0]        amt_wide;
  logic [REM_W-1:0]   eff_ls, eff_as, eff_ror;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   step_value;
  logic               step_carry;
  logic               load_out;

  // Effective amount per operation class.
  assign amt_wide = 64'(amt);
  assign eff_ls   = (amt_wide > LIM_LS) ? REM_W'(LIM_LS) : REM_W'(amt_wide);
  assign eff_as   = (amt_wide > LIM_AS) ? REM_W'(LIM_AS) : REM_W'(amt_wide);
  assign eff_ror  = REM_W'(amt_wide % LIM_AS);

  assign k = (rem_q < REM_W'(STEP)) ? KW'(rem_q) : KW'(STEP);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value   (value_q),
    .op      (op_q),
    .k       (k),
    .shifted (step_value),
    .carry   (step_carry)
  );

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    op_d     = op_q;
    carry_d  = carry_q;
    rem_d    = rem_q;
    rd_d     = rd_q;
    flags_d  = flags_q;
    load_out = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Defaults give amt==0 / illegal-op behaviour: rd=rm, C=cin.
          value_d = rm;
          carry_d = cin;
          op_d    = LSL;
          rem_d   = '0;
          case (op)
            LSL: begin op_d = LSL; rem_d = eff_ls; end
            LSR: begin op_d = LSR; rem_d = eff_ls; end
            ASR: begin op_d = ASR; rem_d = eff_as; end
            ROR: begin
              op_d  = ROR;
              rem_d = eff_ror;
              // Non-zero multiple of WIDTH: value unchanged, C from MSB.
              if ((amt != '0) && (eff_ror == '0)) carry_d = rm[WIDTH-1];
            end
            RRX: begin
              value_d = {cin, rm[WIDTH-1:1]};
              carry_d = rm[0];
            end
            default: ;
          endcase
          if (rem_d == '0) begin
            state_d  = DONE;
            load_out = 1'b1;
          end else begin
            state_d  = SHIFT;
          end
        end
      end
      SHIFT: begin
        value_d = step_value;
        carry_d = step_carry;
        rem_d   = rem_q - REM_W'(k);
        if (rem_d == '0) begin
          state_d  = DONE;
          load_out = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Result registers change only when entering DONE, so they stay
    // stable across any amount of output backpressure.
    if (load_out) begin
      rd_d            = value_d;
      flags_d[FLAG_N] = value_d[WIDTH-1];
      flags_d[FLAG_Z] = (value_d == '0);
      flags_d[FLAG_C] = carry_d;
      flags_d[FLAG_V] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      value_q <= '0;
      op_q    <= LSL;
      carry_q <= 1'b0;
      rem_q   <= '0;
      rd_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
      rd_q    <= rd_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign rd        = rd_q;
  assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shifter
// Description : Self-checking bench for seq_shifter (WIDTH=32, STEP=4).
//               Directed cases plus randomized requests compared against an
//               ARM shift-rule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int AMT_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [WIDTH-1:0]  rm;
  logic [AMT_W-1:0]  amt;
  logic              cin;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  rd;
  logic [3:0]        flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_shifter #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rm        (rm),
    .amt       (amt),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .flags     (flags)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ARM register-specified shift rules, written case by case.
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] r, input int a,
                                    input logic c, output logic [31:0] er, output logic ec,
                                    output int lat);
    int eff;
    er  = r;
    ec  = c;
    eff = 0;
    if (o == 3'd4) begin
      er = {c, r[31:1]};
      ec = r[0];
    end else if (o > 3'd4 || a == 0) begin
      er = r;
      ec = c;
    end else begin
      case (o)
        3'd0: begin
          eff = (a > 33) ? 33 : a;
          if (a < 32) begin er = r << a; ec = r[32-a]; end
          else begin er = 32'd0; ec = (a == 32) ? r[0] : 1'b0; end
        end
        3'd1: begin
          eff = (a > 33) ? 33 : a;
          if (a < 32) begin er = r >> a; ec = r[a-1]; end
          else begin er = 32'd0; ec = (a == 32) ? r[31] : 1'b0; end
        end
        3'd2: begin
          eff = (a > 32) ? 32 : a;
          if (a < 32) begin er = $signed(r) >>> a; ec = r[a-1]; end
          else begin er = {32{r[31]}}; ec = r[31]; end
        end
        default: begin
          eff = a % 32;
          if (eff == 0) ec = r[31];
          else begin er = (r >> eff) | (r << (32 - eff)); ec = er[31]; end
        end
      endcase
    end
    lat = 1 + (eff + STEP - 1) / STEP;
  endfunction

  // Issues one request (called just after a rising edge with the unit idle),
  // checks latency/result, holds backpressure for 'hold' cycles, then drains.
  task automatic run_op(input logic [2:0] o, input logic [31:0] r, input logic [7:0] a,
                        input logic c, input int hold, input bit pester);
    logic [31:0] er;
    logic        ec;
    int          elat;
    int          lat;
    logic [3:0]  ef;
    ref_model(o, r, int'(a), c, er, ec, elat);
    ef = {er[31], (er == 32'd0), ec, 1'b0};
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; rm = r; amt = a; cin = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (pester) begin
        in_valid = 1'b1; op = 3'($urandom_range(0, 4)); rm = $urandom; amt = 8'($urandom);
        check_eq("in_ready_busy", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check_eq("out_valid", 32'(out_valid), 32'd1);
    check_eq("latency", 32'(lat), 32'(elat));
    check_eq("rd", rd, er);
    check_eq("flags", 32'(flags), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_rd", rd, er);
      check_eq("hold_flags", 32'(flags), 32'(ef));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("drain_valid", 32'(out_valid), 32'd0);
    check_eq("drain_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; rm = 32'd0; amt = 8'd0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_rd", rd, 32'd0);
    check_eq("rst_flags", 32'(flags), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(3'd0, 32'h0000_0001, 8'd4,  1'b0, 0, 1'b0);
    run_op(3'd2, 32'h8000_0000, 8'd40, 1'b0, 0, 1'b1);
    run_op(3'd3, 32'h0000_00F1, 8'd4,  1'b0, 0, 1'b0);
    run_op(3'd3, 32'h8000_0000, 8'd32, 1'b0, 0, 1'b0);
    run_op(3'd1, 32'h8000_0001, 8'd33, 1'b0, 0, 1'b0);
    run_op(3'd0, 32'h0000_0005, 8'd0,  1'b1, 0, 1'b0);
    run_op(3'd4, 32'h0000_0003, 8'd0,  1'b1, 0, 1'b0);
    run_op(3'd0, 32'h8000_0001, 8'd32, 1'b0, 0, 1'b0);
    run_op(3'd1, 32'h8000_0001, 8'd32, 1'b0, 0, 1'b0);
    run_op(3'd6, 32'h1234_5678, 8'd9,  1'b1, 0, 1'b0);
    run_op(3'd1, 32'hF0F0_1234, 8'd7,  1'b1, 5, 1'b0);

    // Reset while shifting abandons the operation
    in_valid = 1'b1; op = 3'd0; rm = 32'hDEAD_BEEF; amt = 8'd20; cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("midshift_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_shift_valid", 32'(out_valid), 32'd0);
    check_eq("rst_shift_ready", 32'(in_ready), 32'd1);
    check_eq("rst_shift_rd", rd, 32'd0);
    check_eq("rst_shift_flags", 32'(flags), 32'd0);
    run_op(3'd0, 32'h0000_0003, 8'd1, 1'b0, 0, 1'b0);

    // Randomized requests, amounts biased toward the boundaries
    for (int n = 0; n < 150; n++) begin
      logic [7:0] a;
      case ($urandom_range(0, 5))
        0:       a = 8'd0;
        1:       a = 8'd32;
        2:       a = 8'd33;
        3:       a = 8'd64;
        4:       a = 8'($urandom_range(0, 255));
        default: a = 8'($urandom_range(1, 31));
      endcase
      run_op(3'($urandom_range(0, 7)), $urandom, a, 1'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised multi-cycle ARM-style shift unit; successor to the single-cycle combinational datapath shifter.
- Handles LSL/LSR/ASR/ROR/RRX with full register-specified ARM semantics, including over-range amounts and carry-out.
- Iterates STEP bits per cycle behind a valid/ready handshake.
- Sits between register read and ALU in the multi-cycle datapath; produces result plus {N,Z,C,V} shifter flags.

Parameters:
- WIDTH, 32, data width of Rm and result.
- STEP, 1, max bits shifted per cycle; legal 1..WIDTH.
- AMT_W, 8, shift-amount width (ARM Rs[7:0]).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- op  input  3  shift_op_t: LSL=0, LSR=1, ASR=2, ROR=3, RRX=4.
- rm  input  WIDTH  operand.
- amt  input  AMT_W  shift amount.
- cin  input  1  current C flag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- rd  output  WIDTH  shifted result.
- flags  output  4  {N,Z,C,V}.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset: state=IDLE, in_ready=1, out_valid=0, rd=0, flags=0.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- Accept = in_valid && in_ready. On accept, latch value=rm, op, carry=cin, rem=eff.
  - Next state is DONE if eff==0, else SHIFT.
  - Special ROR case (see below) goes directly to DONE.
- eff computation:
  - LSL/LSR: min(amt, WIDTH+1).
  - ASR: min(amt, WIDTH).
  - ROR: amt mod WIDTH.
  - RRX: 0.
- SHIFT: each cycle shift by k=min(STEP, rem); rem-=k; carry=last bit shifted out. When rem reaches 0, go to DONE.
  - LSL fills 0, carry=value[WIDTH-k].
  - LSR fills 0, carry=value[k-1].
  - ASR fills value[WIDTH-1], carry=value[k-1].
  - ROR rotates, carry=value[k-1].
- Latency, accept to out_valid: 1 + ceil(eff/STEP) cycles.
- Result rules, matching ARM register-specified shifts:
  - amt==0 (any op except RRX): rd=rm, C=cin.
  - LSL/LSR amt==WIDTH: rd=0, C=rm[0] for LSL, rm[WIDTH-1] for LSR.
  - LSL/LSR amt>WIDTH: rd=0, C=0.
  - ASR amt>=WIDTH: rd=all rm[WIDTH-1], C=rm[WIDTH-1].
  - ROR amt!=0, amt mod WIDTH==0: rd=rm, C=rm[WIDTH-1], no SHIFT cycles.
  - ROR otherwise: C=rd[WIDTH-1].
  - RRX: rd={cin, rm[WIDTH-1:1]}, C=rm[0], latency 1.
- Flags: N=rd[WIDTH-1]; Z=(rd==0); C per rules above; V=0 always.
- DONE: rd/flags held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE; out_valid drops next cycle.
  - No same-cycle re-accept, so at most one request is in flight.
- in_valid while busy: ignored, not queued; the requester must hold it.
- reset mid-SHIFT or in DONE: abandon operation; IDLE next cycle, out_valid=0.
- Illegal op (5-7): treated as LSL amt 0, i.e. rd=rm, C=cin.

Decomposition:
- Package shifter_pkg:
  - shift_op_t enum.
  - state_t enum {IDLE, SHIFT, DONE}.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module shift_step: combinational, parameters WIDTH/STEP.
  - Inputs: value, op, k.
  - Outputs: shifted value, carry-out.
  - Instantiated once per cycle's step.
- Top module holds the FSM, eff clamp, rem counter and output registers.

Test Plan (WIDTH=32, STEP=4):
- LSL rm=0x00000001 amt=4 cin=0 -> rd=0x00000010, flags=0000, out_valid 2 cycles after accept.
- ASR rm=0x80000000 amt=40 -> rd=0xFFFFFFFF, flags=1010 (N=1,C=1), latency 9 cycles; in_valid pulses during SHIFT not accepted.
- ROR rm=0x000000F1 amt=4 -> rd=0x1000000F, C=0. ROR rm=0x80000000 amt=32 -> rd=0x80000000, flags=1010, latency 1.
- LSR rm=0x80000001 amt=33 -> rd=0, flags=0100. LSL rm=0x5 amt=0 cin=1 -> rd=0x5, C=1, latency 1.
- RRX rm=0x00000003 cin=1 -> rd=0x80000001, flags=1010.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles in DONE -> rd/flags/out_valid stable.
  - Assert reset during SHIFT of LSL amt=20 -> next cycle out_valid=0, in_ready=1, rd=0.
